// File: rtl/dcache_writeback_buffer.sv
// Writeback buffer behind the 2-way MEM-stage data cache.
// Collects dirty victims from both lanes, coalesces repeat writes to queued
// lines, drains them in FIFO order to memory, and answers miss-path probes.
module dcache_writeback_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write_dirty1,
  input  logic [ADDR_W-1:0] write_dirty1_Addr,
  input  logic [DATA_W-1:0] write_dirty1_Data,
  input  logic              write_dirty2,
  input  logic [ADDR_W-1:0] write_dirty2_Addr,
  input  logic [DATA_W-1:0] write_dirty2_Data,
  output logic              wb_stall,
  output logic              wb_overflow,
  output logic              m_req_valid,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [DATA_W-1:0] m_req_data,
  input  logic              m_req_ready,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [DATA_W-1:0] lookup_data,
  input  logic              flush,
  output logic              flush_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_W - 3;

  // Only the word address is kept; byte offsets never take part in matching.
  logic [TW-1:0]     tag_q  [DEPTH];
  logic [TW-1:0]     tag_d  [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PW-1:0]     head_q, head_d;
  logic [PW-1:0]     tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              stall_q;
  logic              fdone_q;

  logic              lane_v    [2];
  logic [TW-1:0]     lane_tag  [2];
  logic [DATA_W-1:0] lane_data [2];
  logic              deq;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{write_dirty1_Addr[2:0], write_dirty2_Addr[2:0], lookup_addr[2:0]};

  // Lane 2 is younger, so a same-line pair collapses onto lane 2 alone.
  assign lane_tag[0]  = write_dirty1_Addr[ADDR_W-1:3];
  assign lane_tag[1]  = write_dirty2_Addr[ADDR_W-1:3];
  assign lane_data[0] = write_dirty1_Data;
  assign lane_data[1] = write_dirty2_Data;
  assign lane_v[0]    = write_dirty1 & ~(write_dirty2 & (lane_tag[0] == lane_tag[1]));
  assign lane_v[1]    = write_dirty2;

  assign deq = (count_q != '0) & m_req_ready;

  // Next-state: lane 1 then lane 2 coalesce or allocate, then the head retires.
  always_comb begin : enq_logic
    logic [PW-1:0] idx;
    logic [PW-1:0] slot;
    logic          hit;
    logic [CW-1:0] n_alloc;
    tag_d   = tag_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    ovf_d   = ovf_q;
    n_alloc = '0;
    idx     = '0;
    slot    = '0;
    hit     = 1'b0;
    for (int l = 0; l < 2; l++) begin
      hit  = 1'b0;
      slot = '0;
      // The head may already be on the bus, so it is excluded from coalescing.
      for (int i = 1; i < DEPTH; i++) begin
        idx = head_q + PW'(i);
        if ((CW'(i) < count_q) && (tag_q[idx] == lane_tag[l])) begin
          hit  = 1'b1;
          slot = idx;
        end
      end
      if (lane_v[l]) begin
        if (hit) begin
          data_d[slot] = lane_data[l];
        end else if ((count_q + n_alloc) < CW'(DEPTH)) begin
          tag_d[tail_d]  = lane_tag[l];
          data_d[tail_d] = lane_data[l];
          tail_d         = tail_d + 1'b1;
          n_alloc        = n_alloc + 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end
    if (deq) begin
      head_d = head_q + 1'b1;
    end
    count_d = count_q + n_alloc - CW'(deq);
  end

  // State and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      stall_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      tag_q   <= tag_d;
      data_q  <= data_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      stall_q <= (count_d > CW'(DEPTH - 2));
      fdone_q <= flush & (count_q == '0);
    end
  end

  // Probe: scan oldest to youngest so the youngest match is the one kept.
  always_comb begin : lookup_logic
    logic [PW-1:0] idx;
    idx         = '0;
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (tag_q[idx] == lookup_addr[ADDR_W-1:3])) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  assign m_req_valid = (count_q != '0);
  assign m_req_addr  = m_req_valid ? {tag_q[head_q], 3'b000} : '0;
  assign m_req_data  = m_req_valid ? data_q[head_q] : '0;
  assign wb_stall    = stall_q;
  assign wb_overflow = ovf_q;
  assign flush_done  = fdone_q;

endmodule
